mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory access controller that sits directly downstream of the memory address register. It takes the 13-bit address presented by the MAR, plus a read/write command and write data, and runs one handshaked transaction on the external memory bus. On completion it returns read data toward the memory data register and pulses a done strobe to the control unit.

## Interface

Parameters:
- ADDR_W, 13, address width; matches the MAR output.
- DATA_W, 16, data width of the memory word.
- TIMEOUT_CYCLES, 15, maximum number of cycles spent in REQ before abort; used only when the timeout feature is compiled in; legal range 1..255.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  transaction request from the control unit; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  ADDR_W  address from MAR; sampled with req.
- wdata  input  DATA_W  write data; sampled with req.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle completion strobe.
- err  output  1  timeout flag; valid during done.
- rdata  output  DATA_W  last read data captured.
- mem_cs  output  1  memory chip select.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid when mem_ack is high.
- mem_ack  input  1  memory completion acknowledge.

## Operation

- All outputs are registered.
- Reset values: every output is 0, state is IDLE, and the timeout counter is 0. Reset asserted mid-transaction drops mem_cs asynchronously and abandons the transaction with no done pulse.
- IDLE:
  - If req=1 at the clock edge, latch addr, we and wdata into mem_addr, mem_we and mem_wdata, set mem_cs=1 and busy=1, then go to REQ.
  - Otherwise hold all state.
- REQ:
  - mem_cs, mem_we, mem_addr and mem_wdata hold stable.
  - If mem_ack=1 at the edge:
    - For a read, capture mem_rdata into rdata.
    - Clear mem_cs and mem_we, set done=1, go to DONE.
  - Otherwise increment the timeout counter (see Configuration).
- DONE:
  - done and busy are high for exactly this one cycle.
  - The next edge returns to IDLE and clears done, err and busy.
- req while busy=1 (REQ or DONE) is ignored and not queued. Back-to-back transactions need req high in IDLE, so the minimum spacing between accepts is 3 cycles.
- mem_ack while in IDLE or DONE is ignored.
- rdata changes only on a completed read. Writes and timeouts leave it unchanged.
- mem_addr and mem_wdata keep their last values after a transaction; only mem_cs qualifies them.
- The timeout counter is 8 bits wide, clears on entry to REQ, and never wraps because it is bounded by TIMEOUT_CYCLES.

## Timing

- Edge 0 samples req=1, so mem_cs is high from cycle 1.
- If mem_ack is high in cycle 1, it is sampled at edge 1: done is high in cycle 2 and busy is low from cycle 3. This is the minimum latency: 2 cycles from req to done.
- With N wait cycles before mem_ack, done is high in cycle 2+N.
- mem_rdata must be valid in the same cycle that mem_ack is high. rdata is valid from the done cycle onward.
- mem_cs falls in the same cycle that done rises.

## Configuration

- Macro: MEM_ACCESS_CTRL_TIMEOUT_EN.
- Defined:
  - In REQ, the counter increments on each edge without ack.
  - On the edge where the counter equals TIMEOUT_CYCLES-1 with mem_ack still low, clear mem_cs, set done=1 and err=1, and go to DONE.
  - If mem_ack=1 on that same edge, the ack wins and err=0.
- Undefined:
  - No counter logic is present; REQ waits for mem_ack indefinitely.
  - err is tied to 0.

## Test plan

- Reset: assert rst asynchronously mid-REQ, away from a clock edge -> mem_cs, busy, done, err and rdata all go to 0 immediately; after release, state is IDLE.
- Zero-wait read: req=1, we=0, addr=13'h0A5; mem_ack=1 with mem_rdata=16'hBEEF in the cycle after mem_cs rises -> done in cycle 2, rdata=16'hBEEF, err=0, mem_addr=13'h0A5.
- Write with 3 wait cycles: req=1, we=1, addr=13'h1FFF, wdata=16'h1234 -> mem_we=1 and mem_wdata=16'h1234 held for 4 cycles; done in cycle 5; rdata unchanged.
- Ignored request: pulse req with addr=13'h0001 while busy=1 -> no second transaction; mem_addr stays at the original address.
- Timeout (macro defined, TIMEOUT_CYCLES=4): read with mem_ack held at 0 -> done=1 and err=1 in cycle 5, mem_cs low, rdata unchanged. Repeat with mem_ack=1 on the final counted edge -> err=0 and data is captured.
- Back-to-back: raise req again in the IDLE cycle right after done -> the second transaction is accepted and completes correctly, 3 cycles between accepts.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory access controller: runs one handshaked transaction on the external memory bus per request.
// Optional REQ timeout is compiled in with `define MEM_ACCESS_CTRL_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int ADDR_W         = 13,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_d;

    logic              busy_d;
    logic              done_d;
    logic [DATA_W-1:0] rdata_d;
    logic              cs_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              timeout_hit;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt, cnt_d;
    logic       err_d;

    // Ack on the final counted edge takes priority, so only an unacked last edge aborts.
    assign timeout_hit = (cnt == TO_LAST);
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
            err       <= 1'b0;
            cnt       <= '0;
`endif
        end else begin
            state     <= state_d;
            busy      <= busy_d;
            done      <= done_d;
            rdata     <= rdata_d;
            mem_cs    <= cs_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
            err       <= err_d;
            cnt       <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (req) state_d = S_REQ;
            S_REQ:   if (mem_ack || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d  = busy;
        done_d  = done;
        rdata_d = rdata;
        cs_d    = mem_cs;
        we_d    = mem_we;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
        err_d   = err;
        cnt_d   = cnt;
`endif
        case (state)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    cs_d    = 1'b1;
                    busy_d  = 1'b1;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    if (!mem_we) rdata_d = mem_rdata;
                    cs_d   = 1'b0;
                    we_d   = 1'b0;
                    done_d = 1'b1;
                end else if (timeout_hit) begin
                    cs_d   = 1'b0;
                    we_d   = 1'b0;
                    done_d = 1'b1;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
                    err_d  = 1'b1;
`endif
                end else begin
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
                    cnt_d  = cnt + 8'd1;
`endif
                end
            end
            S_DONE: begin
                done_d = 1'b0;
                busy_d = 1'b0;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
                err_d  = 1'b0;
`endif
            end
            default: begin
                done_d = 1'b0;
                busy_d = 1'b0;
                cs_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized transactions
// checked against a transaction-level reference model.
module tb_mem_access_ctrl;

    localparam int AW = 13;
    localparam int DW = 16;
    localparam int TO = 4;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] rdata;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: last completed read data.
    logic [DW-1:0] model_rdata = '0;
    logic [DW-1:0] exp_q[$];

    mem_access_ctrl #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .we(we),
        .addr(addr),
        .wdata(wdata),
        .busy(busy),
        .done(done),
        .err(err),
        .rdata(rdata),
        .mem_cs(mem_cs),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge in an IDLE cycle; returns at the negedge of the following IDLE cycle.
    task automatic run_txn(input logic t_we, input logic [AW-1:0] t_addr,
                           input logic [DW-1:0] t_wdata, input logic [DW-1:0] t_rd,
                           input int n_wait, input bit poke);
        bit timed_out;
        int waits;
        logic [DW-1:0] exp_rd;
        timed_out = TO_EN && (n_wait >= TO);
        waits     = timed_out ? TO - 1 : n_wait;
        exp_rd    = (!timed_out && !t_we) ? t_rd : model_rdata;
        exp_q.push_back(exp_rd);

        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; mem_ack = 1'b0;
        @(negedge clk);
        we = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
        for (int c = 1; c <= waits + 1; c++) begin
            check("req_cs", 32'(mem_cs), 32'd1);
            check("req_busy", 32'(busy), 32'd1);
            check("req_done", 32'(done), 32'd0);
            check("req_we", 32'(mem_we), 32'(t_we));
            check("req_addr", 32'(mem_addr), 32'(t_addr));
            check("req_wdata", 32'(mem_wdata), 32'(t_wdata));
            check("req_rdata_hold", 32'(rdata), 32'(model_rdata));
            mem_ack   = (c == waits + 1) && !timed_out;
            mem_rdata = mem_ack ? t_rd : DW'($urandom);
            if (poke && c == 1) begin
                req = 1'b1; addr = 13'h0001;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
        end
        model_rdata = exp_q.pop_front();
        check("done_strobe", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("done_cs", 32'(mem_cs), 32'd0);
        check("done_we", 32'(mem_we), 32'd0);
        check("done_err", 32'(err), 32'(timed_out));
        check("done_rdata", 32'(rdata), 32'(model_rdata));
        check("done_addr", 32'(mem_addr), 32'(t_addr));
        check("done_wdata", 32'(mem_wdata), 32'(t_wdata));
        mem_ack = 1'($urandom); mem_rdata = DW'($urandom);
        req = poke; addr = 13'h0001;
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_err", 32'(err), 32'd0);
        check("idle_cs", 32'(mem_cs), 32'd0);
        check("idle_rdata", 32'(rdata), 32'(model_rdata));
        check("idle_addr", 32'(mem_addr), 32'(t_addr));
        req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req = 1'b0; mem_ack = 1'($urandom); mem_rdata = DW'($urandom);
            @(negedge clk);
            check("gap_cs", 32'(mem_cs), 32'd0);
            check("gap_done", 32'(done), 32'd0);
            check("gap_rdata", 32'(rdata), 32'(model_rdata));
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_cs", 32'(mem_cs), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(1'b0, 13'h0A5, 16'h0000, 16'hBEEF, 0, 1'b0);
        run_txn(1'b1, 13'h1FFF, 16'h1234, 16'h5555, 3, 1'b1);

        // Asynchronous reset in the middle of a REQ cycle.
        req = 1'b1; we = 1'b0; addr = 13'h0123; wdata = 16'h0;
        @(negedge clk);
        req = 1'b0;
        check("pre_rst_cs", 32'(mem_cs), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_rdata = '0;
        check("arst_cs", 32'(mem_cs), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check("arst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        @(negedge clk);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_rdata", 32'(rdata), 32'd0);
        mem_ack = 1'b0;

        // Back-to-back: second request raised in the IDLE cycle right after done.
        run_txn(1'b0, 13'h0F0F, 16'h0, 16'hA5A5, 0, 1'b0);
        run_txn(1'b0, 13'h0101, 16'h0, 16'h3C3C, 1, 1'b0);
        run_txn(1'b1, 13'h0202, 16'h9876, 16'h0, 0, 1'b0);

        if (TO_EN) begin
            run_txn(1'b0, 13'h0777, 16'h0, 16'hDEAD, TO + 3, 1'b0);
            run_txn(1'b0, 13'h0778, 16'h0, 16'hCAFE, TO - 1, 1'b0);
        end

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                    int'($urandom_range(0, TO + 2)), 1'($urandom));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
